// File: rtl/sample_delay_line_pkg.sv
// Shared sample types and helpers for the ADC -> delay -> DAC sample path.
package sample_pkg;

   localparam int unsigned SAMPLE_W            = 14;
   localparam int unsigned DEFAULT_DELAY_DEPTH = 16;

   typedef logic [SAMPLE_W-1:0] sample_t;

   // DAC inputs expect offset binary at 12 bits: flip the sign bit, drop 2 LSBs.
   function automatic logic [SAMPLE_W-3:0] to_offset_binary(input sample_t s);
      sample_t t;
      t             = s;
      t[SAMPLE_W-1] = ~t[SAMPLE_W-1];
      return t[SAMPLE_W-1:2];
   endfunction

endpackage

// File: rtl/sample_delay_line_if.sv
// Sample-stream bundle between a strobe/sample producer and the delay line.
interface sample_delay_line_if
   import sample_pkg::*;
#(
   parameter  int unsigned WIDTH = SAMPLE_W,
   parameter  int unsigned DEPTH = DEFAULT_DELAY_DEPTH,
   localparam int unsigned AW    = $clog2(DEPTH)
);

   logic             sample_strobe;
   logic [WIDTH-1:0] din;
   logic [AW-1:0]    delay_sel;
   logic             bypass;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             filled;

   modport master (
      output sample_strobe, din, delay_sel, bypass,
      input  dout, dout_valid, filled
   );

   modport slave (
      input  sample_strobe, din, delay_sel, bypass,
      output dout, dout_valid, filled
   );

endinterface

// File: rtl/sample_delay_line_strobe_edge_detect.sv
// Rising-edge detector for a slow strobe synchronous to clk_in.
module strobe_edge_detect (
   input  logic clk_in,
   input  logic rst_n,
   input  logic strobe,
   output logic event_o
);

   logic strobe_q;

   // Reset high so a strobe already asserted at reset release is not an event.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) strobe_q <= 1'b1;
      else        strobe_q <= strobe;
   end

   assign event_o = strobe & ~strobe_q;

endmodule

// File: rtl/sample_delay_line.sv
// N-sample circular-buffer delay for ADC sample streams, clocked by strobe events.
module sample_delay_line
   import sample_pkg::*;
#(
   parameter  int unsigned WIDTH = SAMPLE_W,
   parameter  int unsigned DEPTH = DEFAULT_DELAY_DEPTH,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input logic                clk_in,
   input logic                rst_n,
   sample_delay_line_if.slave bus
);

   localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

   logic             ev;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]    fill_cnt_q, fill_cnt_d;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] dout_q,     dout_d;
   logic             valid_q,    valid_d;
   logic             filled_q,   filled_d;

   strobe_edge_detect u_edge (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .strobe  (bus.sample_strobe),
      .event_o (ev)
   );

   always_ff @(posedge clk_in) begin
      if (ev) mem_q[wr_ptr_q] <= bus.din;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      fill_cnt_d = fill_cnt_q;
      dout_d     = dout_q;
      valid_d    = ev;
      filled_d   = (fill_cnt_q >= bus.delay_sel);
      rd_addr    = wr_ptr_q - bus.delay_sel;
      if (ev) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (fill_cnt_q != FILL_MAX) fill_cnt_d = fill_cnt_q + AW'(1);
         // Entries not yet written since reset read as zero, never stale data.
         if (bus.delay_sel == '0)              dout_d = bus.din;
         else if (fill_cnt_q >= bus.delay_sel) dout_d = mem_q[rd_addr];
         else                                  dout_d = '0;
      end
      if (bus.bypass) dout_d = bus.din;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         fill_cnt_q <= '0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         filled_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_cnt_q <= fill_cnt_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         filled_q   <= filled_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_q;
   assign bus.filled     = filled_q;

endmodule

// File: tb/tb_sample_delay_line.sv
// Directed + randomized bench for sample_delay_line against a history-queue model.
module tb_sample_delay_line;
   import sample_pkg::*;

   localparam int unsigned W = 14;
   localparam int unsigned D = 16;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b1;

   always #5 clk_in = ~clk_in;

   sample_delay_line_if #(.WIDTH(W), .DEPTH(D)) bus ();

   sample_delay_line #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   int cur_d  = 0;
   logic [W-1:0] hist [$];
   logic [W-1:0] last_exp = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every sample since reset is kept; the delayed output is the one d events back.
   function automatic logic [W-1:0] model_out(input logic [W-1:0] v, input int d);
      int n;
      n = hist.size();
      if (d == 0)  return v;
      if (n >= d)  return hist[n-d];
      return '0;
   endfunction

   function automatic logic model_filled(input int d);
      int n;
      n = hist.size();
      if (n > int'(D) - 1) n = int'(D) - 1;
      return n >= d;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_event(input logic [W-1:0] v, input int d, input int hold);
      logic [W-1:0] e;
      bus.sample_strobe = 1'b0;
      tick();
      chk("valid_idle", 32'(bus.dout_valid), 32'(0));
      chk("dout_hold_idle", 32'(bus.dout), bus.bypass ? 32'(bus.din) : 32'(last_exp));
      chk("filled", 32'(bus.filled), 32'(model_filled(cur_d)));
      bus.din           = v;
      bus.delay_sel     = 4'(d);
      cur_d             = d;
      bus.sample_strobe = 1'b1;
      e = bus.bypass ? v : model_out(v, d);
      tick();
      chk("dout_event", 32'(bus.dout), 32'(e));
      chk("valid_event", 32'(bus.dout_valid), 32'(1));
      hist.push_back(v);
      last_exp = e;
      for (int i = 1; i < hold; i++) begin
         if (!bus.bypass) bus.din = 14'($urandom);
         tick();
         chk("valid_high", 32'(bus.dout_valid), 32'(0));
         chk("dout_hold_high", 32'(bus.dout), 32'(last_exp));
      end
   endtask

   task automatic do_reset(input logic strobe_lvl, input int d);
      #2;
      rst_n             = 1'b0;
      bus.sample_strobe = strobe_lvl;
      #1;
      chk("rst_dout", 32'(bus.dout), 32'(0));
      chk("rst_valid", 32'(bus.dout_valid), 32'(0));
      chk("rst_filled", 32'(bus.filled), 32'(0));
      hist.delete();
      last_exp      = '0;
      bus.delay_sel = 4'(d);
      cur_d         = d;
      tick();
      tick();
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_valid", 32'(bus.dout_valid), 32'(0));
         chk("post_rst_dout", 32'(bus.dout), 32'(0));
         chk("post_rst_filled", 32'(bus.filled), 32'(d == 0));
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.sample_strobe = 1'b0;
      bus.din           = '0;
      bus.delay_sel     = 4'd3;
      bus.bypass        = 1'b0;

      do_reset(1'b0, 3);

      for (int k = 1; k <= 8; k++) do_event(14'(k), 3, 2);

      for (int k = 0; k < 4; k++) do_event(14'($urandom), 0, 2);
      do_event(14'($urandom), 0, 10);

      do_reset(1'b0, 15);
      for (int k = 1; k <= 40; k++) do_event(14'(k), 15, 2);
      chk("wrap_last", 32'(bus.dout), 32'(25));

      for (int k = 0; k < 20; k++) do_event(14'($urandom), 2, 2);
      do_event(14'($urandom), 7, 1);
      bus.delay_sel = 4'd1;
      cur_d         = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("dchg_valid", 32'(bus.dout_valid), 32'(0));
         chk("dchg_dout", 32'(bus.dout), 32'(last_exp));
      end
      do_event(14'($urandom), 1, 2);
      do_event(14'($urandom), 1, 2);

      bus.sample_strobe = 1'b0;
      bus.bypass        = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.din = (i % 2 == 0) ? 14'h1234 : 14'h0ABC;
         tick();
         chk("bypass_follow", 32'(bus.dout), 32'(bus.din));
         last_exp = bus.din;
      end
      do_event(14'($urandom), 4, 2);
      bus.bypass = 1'b0;
      do_event(14'($urandom), 5, 2);
      do_event(14'($urandom), 2, 2);

      do_event(14'($urandom), 2, 3);
      do_reset(1'b1, 2);
      for (int k = 0; k < 5; k++) do_event(14'($urandom), 2, 2);

      for (int k = 0; k < 30; k++)
         do_event(14'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_delay_line.md
Name: sample_delay_line

Overview:
- Parametrised N-sample delay for ADC sample streams: the successor to the single-sample hold latch.
- Stores each sample into a circular buffer on every rising edge of the sampling strobe (SPI_SCK-class slow clock) and outputs the sample taken delay_sel events earlier.
- Sits between ADC_Driver channel outputs and the DAC_Driver inputs.
- Adds runtime-selectable delay, bypass mode, fill tracking and an output-valid pulse.

Parameters:
- WIDTH, 14, sample width in bits.
- DEPTH, 16, buffer entries; power of two, at least 2.
- AW, $clog2(DEPTH), pointer and delay-select width; derived, not overridden.

Ports:
- clk_in  input  1  system clock (50 MHz); the only clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_strobe  input  1  sampling strobe, synchronous to clk_in; each 0->1 transition is one sample event.
- din  input  WIDTH  current ADC sample.
- delay_sel  input  AW  delay in sample events, 0..DEPTH-1.
- bypass  input  1  1 = output follows din every clock, independent of events.
- dout  output  WIDTH  delayed sample, registered.
- dout_valid  output  1  one-cycle pulse: dout updated on a sample event.
- filled  output  1  1 = buffer holds at least delay_sel real samples.

Behaviour:
- Reset (async assert, sync release):
  - dout = 0, dout_valid = 0, filled = 0.
  - wr_ptr = 0, fill_cnt = 0.
  - strobe_q = 1, so a strobe already high at reset release does not create an event.
  - Memory contents are not reset.
- Event detection:
  - event = sample_strobe & ~strobe_q, evaluated each clk_in edge.
  - strobe_q <= sample_strobe every cycle.
  - One event per strobe high period, whatever the strobe duty cycle.
- On event, all in the same clk_in edge:
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr + 1, modulo DEPTH.
  - fill_cnt <= min(fill_cnt + 1, DEPTH - 1), saturating.
  - dout_valid <= 1.
- dout on an event, with d = delay_sel sampled on the event cycle:
  - d == 0: dout <= din (one-cycle registered pass-through).
  - d >= 1 and fill_cnt >= d: dout <= mem[(wr_ptr - d) mod DEPTH]. This reads the entry written d events earlier; pointer arithmetic wraps in AW bits.
  - d >= 1 and fill_cnt < d: dout <= 0, so no stale or uninitialised memory reaches the output.
- Latency: dout reflects event k at clk_in edge k+1 and equals din from event k - d.
- No event: dout holds; dout_valid <= 0.
- bypass = 1:
  - dout <= din every cycle.
  - Writes, pointers and dout_valid continue on events, so the history stays intact.
  - On deassertion, the next event outputs the correct delayed sample.
- delay_sel changes:
  - Take effect at the next event only; no intermediate values.
  - Shrinking d outputs an older-stored but valid sample.
  - Growing d beyond fill_cnt outputs 0 until filled.
- filled is registered and equals (fill_cnt >= delay_sel); it updates every cycle.
- Read-during-write: for d >= 1 the read address never equals wr_ptr, so there is no collision. Memory is written and read in the same cycle with a registered read; distributed RAM or registers.
- Reset mid-operation: immediate return to reset values. The history is logically discarded because fill_cnt = 0 forces zero outputs.

Decomposition:
- Shared package sample_pkg:
  - SAMPLE_W = 14 and DEFAULT_DELAY_DEPTH = 16.
  - sample_t typedef (logic [SAMPLE_W-1:0]).
  - Offset-binary conversion helper (invert MSB, drop 2 LSBs), as used at DAC inputs.
- One sub-module, strobe_edge_detect:
  - Ports: clk_in, rst_n, strobe, event.
  - Resets its register to 1; reused by future strobe-driven blocks.
- The memory stays inline.

Test Plan:
- Fill and delay: WIDTH=14, DEPTH=16, delay_sel=3; events with din = 1, 2, 3, ... -> dout = 0, 0, 0, 1, 2, 3, ...; filled rises with the 4th event's fill (fill_cnt = 3); one dout_valid per event.
- delay_sel=0 -> dout equals din of the same event one clk_in later. Hold strobe high 10 cycles -> exactly one event and one valid pulse.
- Wrap-around: delay_sel=15, 40 events with din = event index -> from event 16 on, dout = index - 15; fill_cnt saturates at 15; no glitch across the pointer wrap.
- Live delay change: after 20 events at d=2, set d=7 -> next event outputs din[k-7]. Set d=1 mid strobe-high -> the change applies only at the following event.
- bypass: assert between events with din toggling 0x1234/0x0ABC -> dout follows din with one-cycle lag. Deassert -> the next event outputs the correct delayed history value.
- Reset: assert rst_n=0 mid-stream with strobe high -> all outputs 0 immediately. Release with strobe still high -> no event until a 0->1 strobe edge; the first events at d=2 output 0.
